// File: rtl/axi_pkg.sv
// Shared AXI constants and FSM encodings for the instruction memory slave.
// Burst/response codes, bus widths, read/write state types, WRAP length check.
package axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
  localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) ||
           (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_imem_rd_slave_rom.sv
// imem_rom_ram: synchronous single-port ROM, one-cycle read latency.
// Ports: clk_i, en_i (read enable), addr_i (word index), data_o (held when en_i=0).
module imem_rom_ram #(
  parameter int MEM_ADDR_W = 14,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [MEM_ADDR_W-1:0] addr_i,
  output logic [31:0]           data_o
);

  logic [31:0] mem [2**MEM_ADDR_W];

  initial begin
    for (int i = 0; i < 2**MEM_ADDR_W; i++) mem[i] = '0;
  end

  always_ff @(posedge clk_i) begin
    if (en_i) data_o <= mem[addr_i];
  end

endmodule

// File: rtl/axi_imem_rd_slave.sv
// AXI4 read slave serving instruction bursts from on-chip ROM; writes get SLVERR.
// Ports: clk_i/rst_i, AR/R read channels, AW/W/B write sink channels.
module axi_imem_rd_slave
  import axi_pkg::*;
#(
  parameter int          MEM_ADDR_W = 14,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter              INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  axi_arvalid_i,
  input  logic [31:0]           axi_araddr_i,
  input  logic [AXI_ID_W-1:0]   axi_arid_i,
  input  logic [7:0]            axi_arlen_i,
  input  logic [1:0]            axi_arburst_i,
  output logic                  axi_arready_o,
  output logic                  axi_rvalid_o,
  output logic [AXI_DATA_W-1:0] axi_rdata_o,
  output logic [1:0]            axi_rresp_o,
  output logic [AXI_ID_W-1:0]   axi_rid_o,
  output logic                  axi_rlast_o,
  input  logic                  axi_rready_i,
  input  logic                  axi_awvalid_i,
  input  logic [31:0]           axi_awaddr_i,
  input  logic [AXI_ID_W-1:0]   axi_awid_i,
  input  logic [7:0]            axi_awlen_i,
  input  logic [1:0]            axi_awburst_i,
  output logic                  axi_awready_o,
  input  logic                  axi_wvalid_i,
  input  logic [AXI_DATA_W-1:0] axi_wdata_i,
  input  logic [3:0]            axi_wstrb_i,
  input  logic                  axi_wlast_i,
  output logic                  axi_wready_o,
  output logic                  axi_bvalid_o,
  output logic [1:0]            axi_bresp_o,
  output logic [AXI_ID_W-1:0]   axi_bid_o,
  input  logic                  axi_bready_i
);

  localparam int AW     = MEM_ADDR_W;
  localparam int TAG_LO = MEM_ADDR_W + 2;

  rd_state_t           rstate;
  wr_state_t           wstate;
  logic [AW-1:0]       raddr;
  logic [AW-1:0]       raddr_nxt;
  logic [AW-1:0]       wmask;
  logic [7:0]          rlen;
  logic [1:0]          rburst;
  logic                rerr;
  logic [8:0]          issued;
  logic [8:0]          sent;
  logic                pend;
  logic                take;
  logic                rd_en;
  logic                ar_err;
  logic [31:0]         rom_q;
  logic [AXI_ID_W-1:0] awid_q;

  // Write payload is discarded by design.
  logic unused;
  assign unused = ^{axi_awaddr_i, axi_awlen_i, axi_awburst_i,
                    axi_wdata_i, axi_wstrb_i};

  // Output slot free: the ROM word in flight can move into rdata.
  assign take  = !axi_rvalid_o || axi_rready_i;
  assign rd_en = (rstate == R_BURST) &&
                 (issued <= {1'b0, rlen}) && take;
  assign wmask = AW'(rlen[3:0]);

  assign ar_err =
    (axi_araddr_i[31:TAG_LO] != BASE_ADDR[31:TAG_LO]) ||
    (axi_arburst_i == 2'd3) ||
    ((axi_arburst_i == AXI_BURST_WRAP) &&
     (!wrap_len_ok(axi_arlen_i) || (axi_araddr_i[1:0] != 2'b00)));

  always_comb begin
    raddr_nxt = raddr + 1'b1;
    unique case (1'b1)
      rburst == AXI_BURST_FIXED: raddr_nxt = raddr;
      rburst == AXI_BURST_WRAP:
        raddr_nxt = (raddr & ~wmask) | ((raddr + 1'b1) & wmask);
      default: ;
    endcase
  end

  imem_rom_ram #(
    .MEM_ADDR_W(MEM_ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_rom (
    .clk_i (clk_i),
    .en_i  (rd_en),
    .addr_i(raddr),
    .data_o(rom_q)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rstate        <= R_IDLE;
      axi_arready_o <= 1'b1;
      axi_rvalid_o  <= 1'b0;
      axi_rlast_o   <= 1'b0;
      axi_rdata_o   <= '0;
      axi_rresp_o   <= AXI_RESP_OKAY;
      axi_rid_o     <= '0;
      raddr         <= '0;
      rlen          <= '0;
      rburst        <= AXI_BURST_FIXED;
      rerr          <= 1'b0;
      issued        <= '0;
      sent          <= '0;
      pend          <= 1'b0;
    end else begin
      unique case (rstate)
        R_IDLE: begin
          if (axi_arvalid_i && axi_arready_o) begin
            raddr         <= axi_araddr_i[TAG_LO-1:2];
            rlen          <= axi_arlen_i;
            rburst        <= axi_arburst_i;
            rerr          <= ar_err;
            axi_rid_o     <= axi_arid_i;
            issued        <= '0;
            sent          <= '0;
            pend          <= 1'b0;
            axi_arready_o <= 1'b0;
            rstate        <= R_BURST;
          end
        end
        R_BURST: begin
          if (rd_en) begin
            raddr  <= raddr_nxt;
            issued <= issued + 9'd1;
          end
          // pend marks a ROM word that arrives on rom_q this cycle.
          if (take) begin
            pend         <= rd_en;
            axi_rvalid_o <= pend;
            if (pend) begin
              axi_rdata_o <= rerr ? '0 : rom_q;
              axi_rresp_o <= rerr ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              axi_rlast_o <= (sent == {1'b0, rlen});
              sent        <= sent + 9'd1;
            end
          end
          if (axi_rvalid_o && axi_rready_i && axi_rlast_o) begin
            axi_arready_o <= 1'b1;
            rstate        <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wstate        <= W_IDLE;
      axi_awready_o <= 1'b1;
      axi_wready_o  <= 1'b0;
      axi_bvalid_o  <= 1'b0;
      axi_bresp_o   <= AXI_RESP_OKAY;
      axi_bid_o     <= '0;
      awid_q        <= '0;
    end else begin
      unique case (wstate)
        W_IDLE: begin
          if (axi_awvalid_i && axi_awready_o) begin
            awid_q        <= axi_awid_i;
            axi_awready_o <= 1'b0;
            axi_wready_o  <= 1'b1;
            wstate        <= W_DATA;
          end
        end
        W_DATA: begin
          if (axi_wvalid_i && axi_wready_o && axi_wlast_i) begin
            axi_wready_o <= 1'b0;
            axi_bvalid_o <= 1'b1;
            axi_bresp_o  <= AXI_RESP_SLVERR;
            axi_bid_o    <= awid_q;
            wstate       <= W_RESP;
          end
        end
        W_RESP: begin
          if (axi_bready_i) begin
            axi_bvalid_o  <= 1'b0;
            axi_awready_o <= 1'b1;
            wstate        <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_imem_rd_slave.sv
// Directed bench for axi_imem_rd_slave: bursts, wrap, stalls, errors, writes, reset.
// ROM is preloaded with mem[i]=i; all expectations are hand-derived constants.
module tb_axi_imem_rd_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arvalid = 1'b0;
  logic [31:0] araddr = '0;
  logic [3:0]  arid = '0;
  logic [7:0]  arlen = '0;
  logic [1:0]  arburst = '0;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;
  logic        rready = 1'b0;
  logic        awvalid = 1'b0;
  logic [31:0] awaddr = '0;
  logic [3:0]  awid = '0;
  logic [7:0]  awlen = '0;
  logic [1:0]  awburst = '0;
  logic        awready;
  logic        wvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        bready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [31:0] bd [32];
  logic [1:0]  br [32];
  logic [3:0]  bi [32];
  logic        bl [32];
  int          bc [32];
  int          nb;
  int          stall_bad;
  int          t_acc;
  bit          timed_out;

  axi_imem_rd_slave #(
    .MEM_ADDR_W(14),
    .BASE_ADDR (32'h0000_0000),
    .INIT_FILE ("")
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .axi_arvalid_i(arvalid), .axi_araddr_i(araddr),
    .axi_arid_i(arid), .axi_arlen_i(arlen),
    .axi_arburst_i(arburst), .axi_arready_o(arready),
    .axi_rvalid_o(rvalid), .axi_rdata_o(rdata),
    .axi_rresp_o(rresp), .axi_rid_o(rid),
    .axi_rlast_o(rlast), .axi_rready_i(rready),
    .axi_awvalid_i(awvalid), .axi_awaddr_i(awaddr),
    .axi_awid_i(awid), .axi_awlen_i(awlen),
    .axi_awburst_i(awburst), .axi_awready_o(awready),
    .axi_wvalid_i(wvalid), .axi_wdata_i(wdata),
    .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
    .axi_wready_o(wready), .axi_bvalid_o(bvalid),
    .axi_bresp_o(bresp), .axi_bid_o(bid),
    .axi_bready_i(bready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Issue one AR (called at a negedge) and collect beats until rlast.
  task automatic run_read(input logic [31:0] a, input logic [3:0] id,
                          input logic [7:0] len, input logic [1:0] b,
                          input bit stall);
    int g;
    int k;
    bit held;
    logic [31:0] hd;
    logic [1:0] hr;
    logic hl;
    nb = 0; stall_bad = 0; t_acc = -1; timed_out = 0;
    held = 0; hd = '0; hr = '0; hl = 0;
    araddr = a; arid = id; arlen = len; arburst = b; arvalid = 1;
    g = 0;
    while (!arready && g < 50) begin @(negedge clk); g++; end
    if (!arready) begin arvalid = 0; timed_out = 1; return; end
    t_acc = cyc + 1;
    @(negedge clk);
    arvalid = 0;
    k = 0; g = 0;
    while (g < 600) begin
      rready = stall ? (k % 3 == 0) : 1'b1;
      k++;
      if (rvalid) begin
        if (held && (rdata !== hd || rresp !== hr || rlast !== hl))
          stall_bad++;
        if (rready) begin
          if (nb < 32) begin
            bd[nb] = rdata; br[nb] = rresp; bi[nb] = rid;
            bl[nb] = rlast; bc[nb] = cyc;
          end
          nb++;
          held = 0;
          if (rlast) begin @(negedge clk); rready = 1; return; end
        end else begin
          held = 1; hd = rdata; hr = rresp; hl = rlast;
        end
      end
      @(negedge clk);
      g++;
    end
    timed_out = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (arready !== 1'b1) begin n_bad++; $display("FAIL rst_arready got %b want 1", arready); end
    n_cmp++; if (awready !== 1'b1) begin n_bad++; $display("FAIL rst_awready got %b want 1", awready); end
    n_cmp++; if (rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rvalid got %b want 0", rvalid); end
    n_cmp++; if (rlast !== 1'b0) begin n_bad++; $display("FAIL rst_rlast got %b want 0", rlast); end
    n_cmp++; if (wready !== 1'b0) begin n_bad++; $display("FAIL rst_wready got %b want 0", wready); end
    n_cmp++; if (bvalid !== 1'b0) begin n_bad++; $display("FAIL rst_bvalid got %b want 0", bvalid); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got %h want 0", rdata); end
    n_cmp++; if ({rresp, rid, bresp, bid} !== 12'h0) begin n_bad++; $display("FAIL rst_ids got %h want 0", {rresp, rid, bresp, bid}); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_incr();
    run_read(32'h40, 4'd8, 8'd7, 2'd1, 0);
    n_cmp++; if (timed_out !== 1'b0) begin n_bad++; $display("FAIL incr_timeout got %b want 0", timed_out); end
    n_cmp++; if (nb !== 8) begin n_bad++; $display("FAIL incr_count got %0d want 8", nb); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bd[i] !== 32'h10 + i) begin n_bad++; $display("FAIL incr_data[%0d] got %h want %h", i, bd[i], 32'h10 + i); end
      n_cmp++; if (br[i] !== 2'b00 || bi[i] !== 4'd8) begin n_bad++; $display("FAIL incr_resp_id[%0d] got %b/%h want 00/8", i, br[i], bi[i]); end
      n_cmp++; if (bl[i] !== (i == 7)) begin n_bad++; $display("FAIL incr_last[%0d] got %b want %b", i, bl[i], i == 7); end
      n_cmp++; if (bc[i] !== t_acc + 2 + i) begin n_bad++; $display("FAIL incr_cycle[%0d] got %0d want %0d", i, bc[i], t_acc + 2 + i); end
    end
    n_cmp++; if (arready !== 1'b1 || rvalid !== 1'b0) begin n_bad++; $display("FAIL incr_idle got arready=%b rvalid=%b want 1/0", arready, rvalid); end
  endtask

  task automatic test_wrap();
    int exp_w[4] = '{6, 7, 4, 5};
    run_read(32'h18, 4'd2, 8'd3, 2'd2, 0);
    n_cmp++; if (nb !== 4) begin n_bad++; $display("FAIL wrap_count got %0d want 4", nb); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bd[i] !== 32'(exp_w[i])) begin n_bad++; $display("FAIL wrap_data[%0d] got %h want %h", i, bd[i], exp_w[i]); end
      n_cmp++; if (bl[i] !== (i == 3) || br[i] !== 2'b00) begin n_bad++; $display("FAIL wrap_last[%0d] got %b/%b want %b/00", i, bl[i], br[i], i == 3); end
    end
  endtask

  task automatic test_backpressure();
    run_read(32'h40, 4'd5, 8'd7, 2'd1, 1);
    n_cmp++; if (nb !== 8) begin n_bad++; $display("FAIL bp_count got %0d want 8", nb); end
    n_cmp++; if (stall_bad !== 0) begin n_bad++; $display("FAIL bp_stable got %0d changes want 0", stall_bad); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (bd[i] !== 32'h10 + i) begin n_bad++; $display("FAIL bp_data[%0d] got %h want %h", i, bd[i], 32'h10 + i); end
      n_cmp++; if (bl[i] !== (i == 7)) begin n_bad++; $display("FAIL bp_last[%0d] got %b want %b", i, bl[i], i == 7); end
    end
  endtask

  task automatic test_errors();
    logic [31:0] ea [3] = '{32'h0001_0000, 32'h40, 32'h40};
    logic [7:0]  el [3] = '{8'd1, 8'd3, 8'd2};
    logic [1:0]  eb [3] = '{2'd1, 2'd3, 2'd2};
    for (int c = 0; c < 3; c++) begin
      run_read(ea[c], 4'(c + 1), el[c], eb[c], 0);
      n_cmp++; if (nb !== int'(el[c]) + 1) begin n_bad++; $display("FAIL err%0d_count got %0d want %0d", c, nb, int'(el[c]) + 1); end
      for (int i = 0; i <= int'(el[c]); i++) begin
        n_cmp++; if (br[i] !== 2'b10 || bd[i] !== 32'h0) begin n_bad++; $display("FAIL err%0d_beat[%0d] got %b/%h want 10/0", c, i, br[i], bd[i]); end
        n_cmp++; if (bl[i] !== (i == int'(el[c])) || bi[i] !== 4'(c + 1)) begin n_bad++; $display("FAIL err%0d_last_id[%0d] got %b/%h want %b/%h", c, i, bl[i], bi[i], i == int'(el[c]), c + 1); end
      end
    end
  endtask

  task automatic test_write();
    fork
      begin
        int g;
        int i;
        awaddr = 32'h100; awid = 4'd3; awlen = 8'd2; awburst = 2'd1; awvalid = 1;
        g = 0;
        while (!awready && g < 50) begin @(negedge clk); g++; end
        @(negedge clk);
        awvalid = 0;
        i = 0; g = 0;
        while (i < 3 && g < 50) begin
          if (wready) begin
            wvalid = 1; wdata = 32'hA0 + i; wstrb = 4'hF; wlast = (i == 2); i++;
          end else wvalid = 0;
          @(negedge clk);
          g++;
        end
        wvalid = 0; wlast = 0;
        n_cmp++; if (i !== 3) begin n_bad++; $display("FAIL wr_beats got %0d want 3", i); end
        n_cmp++; if (wready !== 1'b0) begin n_bad++; $display("FAIL wr_wready_resp got %b want 0", wready); end
        for (int j = 0; j < 2; j++) begin
          n_cmp++; if (bvalid !== 1'b1) begin n_bad++; $display("FAIL wr_bvalid_hold[%0d] got %b want 1", j, bvalid); end
          @(negedge clk);
        end
        n_cmp++; if (bvalid !== 1'b1 || bresp !== 2'b10 || bid !== 4'd3) begin n_bad++; $display("FAIL wr_bresp got %b/%b/%h want 1/10/3", bvalid, bresp, bid); end
        bready = 1;
        @(negedge clk);
        bready = 0;
        n_cmp++; if (bvalid !== 1'b0 || awready !== 1'b1) begin n_bad++; $display("FAIL wr_done got bvalid=%b awready=%b want 0/1", bvalid, awready); end
      end
      begin
        run_read(32'h80, 4'd1, 8'd3, 2'd1, 0);
        n_cmp++; if (nb !== 4) begin n_bad++; $display("FAIL wr_rd_count got %0d want 4", nb); end
        for (int i = 0; i < 4; i++) begin
          n_cmp++; if (bd[i] !== 32'h20 + i || bl[i] !== (i == 3)) begin n_bad++; $display("FAIL wr_rd_data[%0d] got %h/%b want %h/%b", i, bd[i], bl[i], 32'h20 + i, i == 3); end
        end
      end
    join
  endtask

  task automatic test_reset_mid();
    int g;
    int n;
    araddr = 32'h0; arid = 4'd7; arlen = 8'd15; arburst = 2'd1; arvalid = 1;
    g = 0;
    while (!arready && g < 50) begin @(negedge clk); g++; end
    @(negedge clk);
    arvalid = 0; rready = 1;
    n = 0; g = 0;
    while (n < 3 && g < 50) begin
      if (rvalid) n++;
      @(negedge clk);
      g++;
    end
    n_cmp++; if (n !== 3 || rvalid !== 1'b1) begin n_bad++; $display("FAIL rm_prefix got %0d beats rvalid=%b want 3/1", n, rvalid); end
    rst = 1;
    #1;
    n_cmp++; if (rvalid !== 1'b0 || rlast !== 1'b0) begin n_bad++; $display("FAIL rm_abort got rvalid=%b rlast=%b want 0/0", rvalid, rlast); end
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    n_cmp++; if (arready !== 1'b1 || rvalid !== 1'b0) begin n_bad++; $display("FAIL rm_idle got arready=%b rvalid=%b want 1/0", arready, rvalid); end
    run_read(32'h100, 4'hA, 8'd3, 2'd1, 0);
    n_cmp++; if (nb !== 4) begin n_bad++; $display("FAIL rm_count got %0d want 4", nb); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bd[i] !== 32'h40 + i || bi[i] !== 4'hA) begin n_bad++; $display("FAIL rm_data[%0d] got %h/%h want %h/a", i, bd[i], bi[i], 32'h40 + i); end
    end
  endtask

  initial begin
    #1;
    for (int i = 0; i < 2**14; i++) dut.u_rom.mem[i] = 32'(i);
    test_reset();
    test_incr();
    test_wrap();
    test_backpressure();
    test_errors();
    test_write();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
